// File: rtl/ptw_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ptw_mem_arbiter
// Shares the single page-table-walk memory read port between the
// instruction-side MMU (I) and the data-side MMU (D).
//  - Round-robin grant with one transaction outstanding at a time.
//  - A walk whose owner is flushed mid-flight is drained: its response is
//    swallowed and never reaches either MMU.
//  - A memory port that stays silent for TIMEOUT_CYCLES cycles is abandoned
//    and the owner receives an error response (TIMEOUT_CYCLES = 0 disables).
//
// Ports
//  clk, rst                 clock, synchronous active-high reset
//  i_req_i/i_addr_i/i_flush_i   instruction-MMU request, PTE address, flush
//  i_rdata_o/i_rvalid_o/i_err_o response to instruction MMU
//  d_*                      same set for the data-side MMU
//  mem_req_o/mem_addr_o     memory read request (level) and address
//  mem_rdata_i/mem_rvalid_i memory read data and completion strobe
//  busy_o                   a transaction is outstanding (BUSY or DRAIN)
//  owner_o                  current or last owner, 0 = I, 1 = D
// ---------------------------------------------------------------------------
module ptw_mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req_i,
   input  logic [31:0] i_addr_i,
   input  logic        i_flush_i,
   output logic [31:0] i_rdata_o,
   output logic        i_rvalid_o,
   output logic        i_err_o,
   input  logic        d_req_i,
   input  logic [31:0] d_addr_i,
   input  logic        d_flush_i,
   output logic [31:0] d_rdata_o,
   output logic        d_rvalid_o,
   output logic        d_err_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_rvalid_i,
   output logic        busy_o,
   output logic        owner_o
);

   // The counter only ever needs to reach TIMEOUT_CYCLES-1.
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 32'd0) ? (TIMEOUT_CYCLES - 32'd1) : 32'd0);
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 32'd0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_BUSY  = 2'b01,
      ST_DRAIN = 2'b10
   } state_t;

   state_t            state_r, state_s;
   logic              owner_r, owner_s;     // doubles as last_owner
   logic [31:0]       addr_r, addr_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;

   logic              elig_i_s, elig_d_s, grant_d_s;
   logic              owner_flush_s, expire_s;
   logic              resp_valid_s, resp_err_s;
   logic [31:0]       resp_data_s;

   assign elig_i_s      = i_req_i & ~i_flush_i;
   assign elig_d_s      = d_req_i & ~d_flush_i;
   assign owner_flush_s = owner_r ? d_flush_i : i_flush_i;
   assign expire_s      = TIMEOUT_EN && (cnt_r == CNT_LAST);

   // State, owner, address and timeout counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         owner_r <= 1'b1;            // I wins the first tie
         addr_r  <= 32'h0000_0000;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_s;
         owner_r <= owner_s;
         addr_r  <= addr_s;
         cnt_r   <= cnt_s;
      end
   end

   // Next-state, grant and response generation.
   always_comb begin
      state_s      = state_r;
      owner_s      = owner_r;
      addr_s       = addr_r;
      cnt_s        = cnt_r;
      grant_d_s    = 1'b0;
      resp_valid_s = 1'b0;
      resp_err_s   = 1'b0;
      resp_data_s  = 32'h0000_0000;
      case (state_r)
         ST_IDLE: begin
            // Stray or late mem_rvalid_i is ignored here.
            if (elig_i_s | elig_d_s) begin
               // On a tie the port that did not own the last walk wins.
               grant_d_s = elig_d_s & (~elig_i_s | ~owner_r);
               owner_s   = grant_d_s;
               addr_s    = grant_d_s ? d_addr_i : i_addr_i;
               cnt_s     = {CNT_W{1'b0}};
               state_s   = ST_BUSY;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            // A response beats both a simultaneous timeout and a flush.
            if (mem_rvalid_i) begin
               resp_valid_s = 1'b1;
               resp_data_s  = mem_rdata_i;
               state_s      = ST_IDLE;
            end else if (expire_s) begin
               resp_valid_s = 1'b1;
               resp_err_s   = 1'b1;
               state_s      = ST_IDLE;
            end else if (owner_flush_s) begin
               cnt_s   = cnt_r + CNT_W'(1);
               state_s = ST_DRAIN;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            // Memory keeps the request; its answer is swallowed.
            if (mem_rvalid_i | expire_s) begin
               state_s = ST_IDLE;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   assign i_rvalid_o = resp_valid_s & ~owner_r;
   assign d_rvalid_o = resp_valid_s &  owner_r;
   assign i_err_o    = resp_err_s   & ~owner_r;
   assign d_err_o    = resp_err_s   &  owner_r;
   assign i_rdata_o  = i_rvalid_o ? resp_data_s : 32'h0000_0000;
   assign d_rdata_o  = d_rvalid_o ? resp_data_s : 32'h0000_0000;

   // Request is a pure function of the registered state.
   assign mem_req_o  = (state_r != ST_IDLE);
   assign busy_o     = (state_r != ST_IDLE);
   assign mem_addr_o = addr_r;
   assign owner_o    = owner_r;

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ptw_mem_arbiter (TIMEOUT_CYCLES = 8): a fixed
// vector table, hand-written corner sequences and a randomized run compared
// against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_ptw_mem_arbiter;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, i_flush, d_req, d_flush, mem_rvalid;
   logic [31:0] i_addr, d_addr, mem_rdata;
   logic [31:0] i_rdata_o, d_rdata_o, mem_addr_o;
   logic        i_rvalid_o, i_err_o, d_rvalid_o, d_err_o;
   logic        mem_req_o, busy_o, owner_o;

   int n_checks = 0;
   int n_fail   = 0;

   ptw_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .i_req_i(i_req), .i_addr_i(i_addr), .i_flush_i(i_flush),
      .i_rdata_o(i_rdata_o), .i_rvalid_o(i_rvalid_o), .i_err_o(i_err_o),
      .d_req_i(d_req), .d_addr_i(d_addr), .d_flush_i(d_flush),
      .d_rdata_o(d_rdata_o), .d_rvalid_o(d_rvalid_o), .d_err_o(d_err_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid),
      .busy_o(busy_o), .owner_o(owner_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_in();
      rst = 1'b0; i_req = 1'b0; i_addr = 32'h0; i_flush = 1'b0;
      d_req = 1'b0; d_addr = 32'h0; d_flush = 1'b0;
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic rst; logic i_req; logic [31:0] i_addr; logic i_flush;
      logic d_req; logic [31:0] d_addr; logic d_flush;
      logic mrv; logic [31:0] mrd;
      logic e_mreq; logic [31:0] e_maddr; logic e_irv; logic [31:0] e_irdata;
      logic e_drv; logic [31:0] e_drdata; logic e_busy; logic e_owner;
   } vec_t;

   function automatic vec_t v(
      input logic r, input logic ir, input logic [31:0] ia, input logic ifl,
      input logic dr, input logic [31:0] da, input logic dfl,
      input logic mv, input logic [31:0] md,
      input logic emq, input logic [31:0] ema, input logic eiv, input logic [31:0] eid,
      input logic edv, input logic [31:0] edd, input logic eb, input logic eo);
      vec_t t;
      t.rst = r; t.i_req = ir; t.i_addr = ia; t.i_flush = ifl;
      t.d_req = dr; t.d_addr = da; t.d_flush = dfl; t.mrv = mv; t.mrd = md;
      t.e_mreq = emq; t.e_maddr = ema; t.e_irv = eiv; t.e_irdata = eid;
      t.e_drv = edv; t.e_drdata = edd; t.e_busy = eb; t.e_owner = eo;
      return t;
   endfunction

   // ---------------- reference model ----------------
   // One record describes the walk in flight: who owns it, its address,
   // how long it has waited and whether its owner has abandoned it.
   bit          m_busy, m_abandoned, m_owner;
   logic [31:0] m_addr;
   int          m_age;
   logic        e_irv, e_drv, e_ierr, e_derr;
   logic [31:0] e_irdata, e_drdata;

   task automatic model_reset();
      m_busy = 0; m_abandoned = 0; m_owner = 1; m_addr = 32'h0; m_age = 0;
   endtask

   task automatic model_eval();
      bit ends, deliver;
      ends    = m_busy && (mem_rvalid === 1'b1 || m_age == TO - 1);
      deliver = ends && !m_abandoned;
      e_irv    = deliver && !m_owner;
      e_drv    = deliver &&  m_owner;
      e_ierr   = e_irv && !mem_rvalid;
      e_derr   = e_drv && !mem_rvalid;
      e_irdata = (e_irv && mem_rvalid) ? mem_rdata : 32'h0;
      e_drdata = (e_drv && mem_rvalid) ? mem_rdata : 32'h0;
   endtask

   task automatic model_advance();
      bit want_i, want_d, win_d;
      if (rst) begin
         model_reset();
      end else if (!m_busy) begin
         want_i = i_req && !i_flush;
         want_d = d_req && !d_flush;
         if (want_i || want_d) begin
            win_d = (want_i && want_d) ? !m_owner : want_d;
            m_owner = win_d; m_addr = win_d ? d_addr : i_addr;
            m_busy = 1; m_abandoned = 0; m_age = 0;
         end
      end else if (mem_rvalid || m_age == TO - 1) begin
         m_busy = 0;
      end else begin
         m_age++;
         if ((m_owner ? d_flush : i_flush) == 1'b1) m_abandoned = 1;
      end
   endtask

   vec_t tbl[16];
   localparam logic [31:0] A1 = 32'h8000_1000, IA = 32'h0000_1000, DA = 32'h0000_2000;

   initial begin
      bit          i_act, d_act;
      logic [31:0] i_a, d_a;

      tbl[0]  = v(0, 1,A1,0, 0,0,0, 0,32'h0,          0,32'h0,0,32'h0, 0,32'h0, 0,1);
      tbl[1]  = v(0, 1,A1,0, 0,0,0, 0,32'h0,          1,A1,0,32'h0,    0,32'h0, 1,0);
      tbl[2]  = v(0, 1,A1,0, 0,0,0, 0,32'h0,          1,A1,0,32'h0,    0,32'h0, 1,0);
      tbl[3]  = v(0, 1,A1,0, 0,0,0, 1,32'h2000_00CF,  1,A1,1,32'h2000_00CF, 0,32'h0, 1,0);
      tbl[4]  = v(0, 0,A1,0, 0,0,0, 0,32'h0,          0,A1,0,32'h0,    0,32'h0, 0,0);
      tbl[5]  = v(1, 0,32'h0,0, 0,32'h0,0, 0,32'h0,   0,A1,0,32'h0,    0,32'h0, 0,0);
      tbl[6]  = v(0, 1,IA,0, 1,DA,0, 0,32'h0,         0,32'h0,0,32'h0, 0,32'h0, 0,1);
      tbl[7]  = v(0, 1,IA,0, 1,DA,0, 0,32'h0,         1,IA,0,32'h0,    0,32'h0, 1,0);
      tbl[8]  = v(0, 1,IA,0, 1,DA,0, 1,32'h11,        1,IA,1,32'h11,   0,32'h0, 1,0);
      tbl[9]  = v(0, 1,IA,0, 1,DA,0, 0,32'h0,         0,IA,0,32'h0,    0,32'h0, 0,0);
      tbl[10] = v(0, 1,IA,0, 1,DA,0, 0,32'h0,         1,DA,0,32'h0,    0,32'h0, 1,1);
      tbl[11] = v(0, 1,IA,0, 1,DA,0, 1,32'h22,        1,DA,0,32'h0,    1,32'h22, 1,1);
      tbl[12] = v(0, 1,IA,0, 1,DA,0, 0,32'h0,         0,DA,0,32'h0,    0,32'h0, 0,1);
      tbl[13] = v(0, 1,IA,0, 1,DA,0, 0,32'h0,         1,IA,0,32'h0,    0,32'h0, 1,0);
      tbl[14] = v(0, 1,IA,0, 1,DA,0, 1,32'h33,        1,IA,1,32'h33,   0,32'h0, 1,0);
      tbl[15] = v(0, 0,IA,0, 0,DA,0, 0,32'h0,         0,IA,0,32'h0,    0,32'h0, 0,0);

      idle_in();
      rst = 1'b1;
      @(negedge clk);
      tick();
      tick();

      // ---- table: single I request, reset, tie round-robin ----
      for (int k = 0; k < 16; k++) begin
         rst = tbl[k].rst; i_req = tbl[k].i_req; i_addr = tbl[k].i_addr; i_flush = tbl[k].i_flush;
         d_req = tbl[k].d_req; d_addr = tbl[k].d_addr; d_flush = tbl[k].d_flush;
         mem_rvalid = tbl[k].mrv; mem_rdata = tbl[k].mrd;
         #1;
         chk($sformatf("tbl%0d_mem_req", k),  mem_req_o,  tbl[k].e_mreq);
         chk($sformatf("tbl%0d_mem_addr", k), mem_addr_o, tbl[k].e_maddr);
         chk($sformatf("tbl%0d_i_rvalid", k), i_rvalid_o, tbl[k].e_irv);
         chk($sformatf("tbl%0d_i_rdata", k),  i_rdata_o,  tbl[k].e_irdata);
         chk($sformatf("tbl%0d_d_rvalid", k), d_rvalid_o, tbl[k].e_drv);
         chk($sformatf("tbl%0d_d_rdata", k),  d_rdata_o,  tbl[k].e_drdata);
         chk($sformatf("tbl%0d_errs", k),     {i_err_o, d_err_o}, 2'b00);
         chk($sformatf("tbl%0d_busy", k),     busy_o,     tbl[k].e_busy);
         chk($sformatf("tbl%0d_owner", k),    owner_o,    tbl[k].e_owner);
         tick();
      end

      // ---- owner flush: D drained, pending I granted afterwards ----
      idle_in(); d_req = 1'b1; d_addr = 32'h0000_3000;
      #1 chk("fl_idle_busy", busy_o, 1'b0);
      tick();
      d_flush = 1'b1; i_req = 1'b1; i_addr = 32'h0000_4000;
      #1 chk("fl_owner", owner_o, 1'b1);
      chk("fl_addr", mem_addr_o, 32'h0000_3000);
      tick();
      d_flush = 1'b0; d_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         mem_rvalid = (k == 3); mem_rdata = 32'hDEAD_BEEF;
         #1 chk("fl_drain_mem_req", mem_req_o, 1'b1);
         chk("fl_drain_addr", mem_addr_o, 32'h0000_3000);
         chk("fl_drain_rvalids", {i_rvalid_o, d_rvalid_o}, 2'b00);
         chk("fl_drain_rdata", d_rdata_o, 32'h0);
         tick();
      end
      mem_rvalid = 1'b0;
      #1 chk("fl_after_busy", busy_o, 1'b0);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h0000_0044;
      #1 chk("fl_i_grant_addr", mem_addr_o, 32'h0000_4000);
      chk("fl_i_grant_owner", owner_o, 1'b0);
      chk("fl_i_rvalid", i_rvalid_o, 1'b1);
      chk("fl_i_rdata", i_rdata_o, 32'h0000_0044);
      tick();

      // ---- owner flush and response in the same cycle ----
      idle_in(); i_req = 1'b1; i_addr = 32'h0000_5000;
      #1 chk("fr_idle", busy_o, 1'b0);
      tick();
      i_flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0055;
      #1 chk("fr_i_rvalid", i_rvalid_o, 1'b1);
      chk("fr_i_rdata", i_rdata_o, 32'h0000_0055);
      chk("fr_i_err", i_err_o, 1'b0);
      tick();
      idle_in();
      #1 chk("fr_after_busy", busy_o, 1'b0);
      tick();

      // ---- timeout on the 8th BUSY cycle, late response ignored ----
      i_req = 1'b1; i_addr = 32'h0000_6000; mem_rdata = 32'hFFFF_FFFF;
      #1 chk("to_idle", busy_o, 1'b0);
      tick();
      for (int k = 1; k <= TO; k++) begin
         #1 chk($sformatf("to_c%0d_rvalid", k), i_rvalid_o, (k == TO));
         chk($sformatf("to_c%0d_err", k), i_err_o, (k == TO));
         chk($sformatf("to_c%0d_rdata", k), i_rdata_o, 32'h0);
         chk($sformatf("to_c%0d_mem_req", k), mem_req_o, 1'b1);
         tick();
      end
      i_req = 1'b0;
      #1 chk("to_after_mem_req", mem_req_o, 1'b0);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077;
      #1 chk("to_late_rvalids", {i_rvalid_o, d_rvalid_o}, 2'b00);
      tick();

      // ---- reset while D is outstanding ----
      idle_in(); d_req = 1'b1; d_addr = 32'h0000_7000;
      tick();
      #1 chk("rb_owner", owner_o, 1'b1);
      chk("rb_mem_req", mem_req_o, 1'b1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; d_req = 1'b0;
      #1 chk("rb_mem_req_after", mem_req_o, 1'b0);
      chk("rb_busy_after", busy_o, 1'b0);
      chk("rb_owner_after", owner_o, 1'b1);
      chk("rb_addr_after", mem_addr_o, 32'h0);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h0000_0088;
      #1 chk("rb_stray_rvalids", {i_rvalid_o, d_rvalid_o}, 2'b00);
      tick();
      mem_rvalid = 1'b0;
      #1 chk("rb_stray_busy", busy_o, 1'b0);

      // ---- randomized run against the model ----
      rst = 1'b1;
      tick();
      model_reset();
      i_act = 0; d_act = 0; i_a = 32'h0; d_a = 32'h0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst = ($urandom_range(0, 299) == 0);
         i_req = i_act; i_addr = i_a; i_flush = ($urandom_range(0, 11) == 0);
         d_req = d_act; d_addr = d_a; d_flush = ($urandom_range(0, 11) == 0);
         mem_rvalid = ($urandom_range(0, 4) == 0); mem_rdata = $urandom;
         #1;
         model_eval();
         chk("rnd_mem_req",  mem_req_o,  m_busy);
         chk("rnd_busy",     busy_o,     m_busy);
         chk("rnd_mem_addr", mem_addr_o, m_addr);
         chk("rnd_owner",    owner_o,    m_owner);
         chk("rnd_i_rvalid", i_rvalid_o, e_irv);
         chk("rnd_i_err",    i_err_o,    e_ierr);
         chk("rnd_i_rdata",  i_rdata_o,  e_irdata);
         chk("rnd_d_rvalid", d_rvalid_o, e_drv);
         chk("rnd_d_err",    d_err_o,    e_derr);
         chk("rnd_d_rdata",  d_rdata_o,  e_drdata);
         if (e_irv) begin
            i_act = ($urandom_range(0, 3) == 0); i_a = $urandom;
         end else if (i_flush && i_act && $urandom_range(0, 1) == 1) begin
            i_act = 0;
         end else if (!i_act && $urandom_range(0, 2) == 0) begin
            i_act = 1; i_a = $urandom;
         end
         if (e_drv) begin
            d_act = ($urandom_range(0, 3) == 0); d_a = $urandom;
         end else if (d_flush && d_act && $urandom_range(0, 1) == 1) begin
            d_act = 0;
         end else if (!d_act && $urandom_range(0, 2) == 0) begin
            d_act = 1; d_a = $urandom;
         end
         model_advance();
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ptw_mem_arbiter.md
Name: ptw_mem_arbiter

Overview:
- Shares the single page-table-walk memory read port between the instruction-side MMU (inside ifu) and the data-side MMU (inside lsu).
- Uses round-robin arbitration and keeps one transaction outstanding at a time.
- Discards the response of a walk whose owner is flushed mid-flight.
- Times out a hung memory port and returns an error to the owner.
- Sits between the two MMU mem interfaces and the memory/cache read port.

Parameters:
- TIMEOUT_CYCLES, 256, cycles in BUSY/DRAIN without mem_rvalid_i before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_req_i  in  1  instruction-MMU read request; level, held until i_rvalid_o
- i_addr_i  in  32  instruction-MMU PTE physical address
- i_flush_i  in  1  instruction-side MMU flush
- i_rdata_o  out  32  PTE data to instruction MMU
- i_rvalid_o  out  1  one-cycle response strobe to instruction MMU
- i_err_o  out  1  response is a timeout error; valid with i_rvalid_o
- d_req_i, d_addr_i, d_flush_i, d_rdata_o, d_rvalid_o, d_err_o  same as i_*, for the data-side MMU
- mem_req_o  out  1  memory read request; level, held until mem_rvalid_i
- mem_addr_o  out  32  memory read address; stable while mem_req_o is high
- mem_rdata_i  in  32  memory read data
- mem_rvalid_i  in  1  memory read data valid; completes the outstanding request
- busy_o  out  1  state != IDLE
- owner_o  out  1  current or last owner; 0 = I, 1 = D

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous, active-high.
- Reset (including mid-transaction):
  - state = IDLE; mem_req_o = 0; mem_addr_o = 0.
  - owner_o = 1 and last_owner = 1, so I wins the first tie.
  - Timeout counter = 0.
  - All rvalid/err/rdata outputs = 0.
  - Any in-flight memory response arriving after reset is ignored.
- States: IDLE, BUSY, DRAIN.
- Eligibility in IDLE: eligible_I = i_req_i & ~i_flush_i; likewise eligible_D.
- IDLE transitions:
  - No eligible port: stay in IDLE.
  - One eligible port: grant it.
  - Both eligible: grant ~last_owner.
  - On grant, at the clock edge: latch the address into mem_addr_o, set owner/last_owner, set mem_req_o = 1, clear the counter, go to BUSY.
- Latency: request sampled at cycle N -> mem_req_o high at N+1.
- BUSY:
  - mem_rvalid_i = 1: owner's rvalid_o = 1 combinationally in the same cycle, rdata_o = mem_rdata_i, err_o = 0. Next edge: mem_req_o = 0, go to IDLE.
  - Owner's flush = 1 without mem_rvalid_i: go to DRAIN; mem_req_o stays high and the address is held.
  - mem_rvalid_i and owner flush in the same cycle: the response is delivered (rvalid_o = 1), then go to IDLE.
  - Non-owner flush: no effect.
- DRAIN:
  - Wait for mem_rvalid_i, swallow it (no rvalid_o to either port), then go to IDLE.
  - Owner's req may drop during DRAIN.
- Timeout (TIMEOUT_CYCLES > 0):
  - The counter increments each BUSY/DRAIN cycle without mem_rvalid_i.
  - When it equals TIMEOUT_CYCLES-1 in BUSY: owner's rvalid_o = 1, err_o = 1, rdata_o = 0; mem_req_o drops; go to IDLE.
  - Same condition in DRAIN: go to IDLE silently.
  - mem_rvalid_i in the same cycle as the timeout wins; it is a normal completion.
- mem_rvalid_i while IDLE (late or stray response): ignored.
- Requester contract: req is deasserted in the cycle after its rvalid unless a new request is intended. A still-high req is treated as a new request.
- Outputs when not responding: rvalid/err = 0; rdata_o = 0.
- No combinational path from any *_req_i to mem_req_o.

Test Plan:
- Single I request: i_req_i = 1, i_addr_i = 0x8000_1000 at cycle 0; mem_rvalid_i with rdata 0x2000_00CF at cycle 3 -> mem_req_o high cycles 1–3, mem_addr_o = 0x8000_1000, i_rvalid_o = 1 with rdata 0x2000_00CF only at cycle 3, d_rvalid_o never asserted, busy_o low at cycle 4.
- Tie round-robin: after reset, I and D request together continuously, memory responds 2 cycles after each request -> grants alternate I, D, I, D; owner_o = 0, 1, 0, 1.
- Owner flush: D is granted, then d_flush_i pulses before the response; mem_rvalid_i arrives 4 cycles later -> state goes to DRAIN, no d_rvalid_o or i_rvalid_o; pending I request granted the cycle after the swallowed response.
- Flush and response in the same cycle: i_flush_i = 1 and mem_rvalid_i = 1 in BUSY with owner I -> i_rvalid_o = 1, data delivered.
- Timeout: TIMEOUT_CYCLES = 8, I granted, memory never responds -> i_rvalid_o = 1, i_err_o = 1, rdata 0 on the 8th BUSY cycle; a later mem_rvalid_i pulse produces no output.
- Reset mid-BUSY: assert rst for one cycle while D is outstanding -> next cycle mem_req_o = 0, busy_o = 0, owner_o = 1; a subsequent mem_rvalid_i is ignored.
